rect_plotter: RTL and testbench



---
 rtl/rect_plotter_if.sv | 46 ++++
 rtl/rect_plotter.sv | 161 ++++++++++++++++
 tb/tb_rect_plotter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/rect_plotter_if.sv
// Shared widths/payload types and the request + pixel-stream bundle for rect_plotter.
//   master: requester side (drives start/rect_*, observes busy/done and the pixel stream)
//   slave : rect_plotter side
package rect_plotter_pkg;

    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 7;
    localparam int unsigned C_W = 3;

    // Latched rectangle-draw request
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [X_W-1:0] w;
        logic [Y_W-1:0] h;
        logic [C_W-1:0] colour;
    } rect_req_t;

endpackage

interface rect_plotter_if;
    import rect_plotter_pkg::*;

    logic           start;
    logic [X_W-1:0] rect_x;
    logic [Y_W-1:0] rect_y;
    logic [X_W-1:0] rect_w;
    logic [Y_W-1:0] rect_h;
    logic [C_W-1:0] rect_colour;
    logic           busy;
    logic           done;
    logic [X_W-1:0] x_out;
    logic [Y_W-1:0] y_out;
    logic [C_W-1:0] colour_out;
    logic           plot;

    modport master (
        output start, rect_x, rect_y, rect_w, rect_h, rect_colour,
        input  busy, done, x_out, y_out, colour_out, plot
    );

    modport slave (
        input  start, rect_x, rect_y, rect_w, rect_h, rect_colour,
        output busy, done, x_out, y_out, colour_out, plot
    );
endinterface

// File: rtl/rect_plotter.sv
// Rectangle pixel-stream generator feeding the vga_adapter plot port.
// Accepts one request in IDLE, scans w*h pixels row-major at one per clock
// (clipping off-screen pixels by dropping plot), then pulses done for one cycle.
// Ports:
//   clk    - system clock
//   resetn - asynchronous active-low reset
//   bus    - rect_plotter_if.slave: start/rect_* request, busy/done handshake,
//            x_out/y_out/colour_out/plot pixel stream (all outputs registered)
module rect_plotter
    import rect_plotter_pkg::*;
#(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120
) (
    input  logic          clk,
    input  logic          resetn,
    rect_plotter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

    state_t         state_q, state_n;
    rect_req_t      req_q, req_n;
    logic [X_W-1:0] col_q, col_n;
    logic [Y_W-1:0] row_q, row_n;
    logic [X_W-1:0] x_q, x_n;
    logic [Y_W-1:0] y_q, y_n;
    logic [C_W-1:0] colour_q, colour_n;
    logic           plot_q, plot_n;
    logic           busy_q, busy_n;
    logic           done_q, done_n;

    // Pixel selected for presentation in the next cycle
    logic           emit;
    logic [X_W-1:0] base_x, pix_col;
    logic [Y_W-1:0] base_y, pix_row;
    logic [C_W-1:0] pix_colour;
    logic [X_W:0]   xsum;
    logic [Y_W:0]   ysum;
    logic           last_col, last_row;

    // Next-state, counter and output computation
    always_comb begin
        state_n    = state_q;
        req_n      = req_q;
        col_n      = col_q;
        row_n      = row_q;
        x_n        = '0;
        y_n        = '0;
        colour_n   = '0;
        plot_n     = 1'b0;
        busy_n     = 1'b0;
        done_n     = 1'b0;
        emit       = 1'b0;
        base_x     = req_q.x;
        base_y     = req_q.y;
        pix_col    = col_q;
        pix_row    = row_q;
        pix_colour = req_q.colour;
        xsum       = '0;
        ysum       = '0;
        last_col   = (col_q == req_q.w - X_W'(1));
        last_row   = (row_q == req_q.h - Y_W'(1));

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    req_n.x      = bus.rect_x;
                    req_n.y      = bus.rect_y;
                    req_n.w      = bus.rect_w;
                    req_n.h      = bus.rect_h;
                    req_n.colour = bus.rect_colour;
                    col_n        = '0;
                    row_n        = '0;
                    busy_n       = 1'b1;
                    if (bus.rect_w == '0 || bus.rect_h == '0) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        // First pixel comes straight from the inputs being latched
                        state_n    = DRAW;
                        emit       = 1'b1;
                        base_x     = bus.rect_x;
                        base_y     = bus.rect_y;
                        pix_col    = '0;
                        pix_row    = '0;
                        pix_colour = bus.rect_colour;
                    end
                end
            end
            DRAW: begin
                busy_n = 1'b1;
                if (last_col && last_row) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    emit = 1'b1;
                    if (last_col) begin
                        col_n = '0;
                        row_n = row_q + Y_W'(1);
                    end else begin
                        col_n = col_q + X_W'(1);
                    end
                    pix_col = col_n;
                    pix_row = row_n;
                end
            end
            DONE: begin
                state_n = IDLE;
                col_n   = '0;
                row_n   = '0;
            end
            default: state_n = IDLE;
        endcase

        // Sums carry one extra bit so wrap-around past the screen edge still clips
        if (emit) begin
            xsum     = (X_W+1)'(base_x) + (X_W+1)'(pix_col);
            ysum     = (Y_W+1)'(base_y) + (Y_W+1)'(pix_row);
            x_n      = xsum[X_W-1:0];
            y_n      = ysum[Y_W-1:0];
            colour_n = pix_colour;
            plot_n   = (xsum < (X_W+1)'(SCREEN_W)) && (ysum < (Y_W+1)'(SCREEN_H));
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            req_q    <= '0;
            col_q    <= '0;
            row_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            req_q    <= req_n;
            col_q    <= col_n;
            row_q    <= row_n;
            x_q      <= x_n;
            y_q      <= y_n;
            colour_q <= colour_n;
            plot_q   <= plot_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
        end
    end

    assign bus.x_out      = x_q;
    assign bus.y_out      = y_q;
    assign bus.colour_out = colour_q;
    assign bus.plot       = plot_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Directed, table-driven bench for rect_plotter.
module tb_rect_plotter;

    logic clk;
    logic resetn;

    rect_plotter_if bus ();

    rect_plotter u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row: inputs applied for an edge, outputs expected in the following cycle
    typedef struct {
        logic       start;
        logic [7:0] rx;
        logic [6:0] ry;
        logic [7:0] rw;
        logic [6:0] rh;
        logic [2:0] rc;
        logic       busy;
        logic       done;
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(input int s, input int rx, input int ry, input int rw,
                                input int rh, input int rc, input int b, input int d,
                                input int p, input int x, input int y, input int c);
        vec_t t;
        t.start = 1'(s);  t.rx = 8'(rx); t.ry = 7'(ry); t.rw = 8'(rw);
        t.rh    = 7'(rh); t.rc = 3'(rc); t.busy = 1'(b); t.done = 1'(d);
        t.plot  = 1'(p);  t.x  = 8'(x);  t.y = 7'(y);   t.c = 3'(c);
        return t;
    endfunction

    task automatic v(input int s, input int rx, input int ry, input int rw, input int rh,
                     input int rc, input int b, input int d, input int p, input int x,
                     input int y, input int c);
        vecs.push_back(mk(s, rx, ry, rw, rh, rc, b, d, p, x, y, c));
    endtask

    task automatic px(input int x, input int y, input int c, input int p);
        v(0, 0, 0, 0, 0, 0, 1, 0, p, x, y, c);
    endtask

    task automatic dn();
        v(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    endtask

    task automatic id();
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drive(input vec_t t);
        bus.start       = t.start;
        bus.rect_x      = t.rx;
        bus.rect_y      = t.ry;
        bus.rect_w      = t.rw;
        bus.rect_h      = t.rh;
        bus.rect_colour = t.rc;
    endtask

    task automatic check(input string name, input vec_t e);
        checks++;
        if (bus.busy !== e.busy || bus.done !== e.done || bus.plot !== e.plot ||
            bus.x_out !== e.x || bus.y_out !== e.y || bus.colour_out !== e.c) begin
            errors++;
            $display("FAIL %s: got busy=%0b done=%0b plot=%0b x=%0d y=%0d c=%0d, expected busy=%0b done=%0b plot=%0b x=%0d y=%0d c=%0d",
                     name, bus.busy, bus.done, bus.plot, bus.x_out, bus.y_out, bus.colour_out,
                     e.busy, e.done, e.plot, e.x, e.y, e.c);
        end
    endtask

    initial begin
        vec_t zero;
        zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Basic 3x2 at (10,20), colour 100
        v(1, 10, 20, 3, 2, 4, 1, 0, 1, 10, 20, 4);
        px(11, 20, 4, 1); px(12, 20, 4, 1);
        px(10, 21, 4, 1); px(11, 21, 4, 1); px(12, 21, 4, 1);
        dn(); id();
        // Empty requests: w=0, then h=0
        v(1, 7, 7, 0, 5, 5, 1, 1, 0, 0, 0, 0); id();
        v(1, 7, 7, 3, 0, 5, 1, 1, 0, 0, 0, 0); id();
        // Clipping at bottom-right corner
        v(1, 158, 119, 4, 2, 2, 1, 0, 1, 158, 119, 2);
        px(159, 119, 2, 1); px(160, 119, 2, 0); px(161, 119, 2, 0);
        px(158, 120, 2, 0); px(159, 120, 2, 0); px(160, 120, 2, 0); px(161, 120, 2, 0);
        dn(); id();
        // x sum wraps past 255: low bits shown, still clipped
        v(1, 254, 0, 3, 1, 7, 1, 0, 0, 254, 0, 7);
        px(255, 0, 7, 0); px(0, 0, 7, 0);
        dn(); id();
        // y sum wraps past 127
        v(1, 5, 127, 1, 2, 1, 1, 0, 0, 5, 127, 1);
        px(5, 0, 1, 0);
        dn(); id();
        // Last visible pixel
        v(1, 159, 119, 1, 1, 3, 1, 0, 1, 159, 119, 3);
        dn(); id();
        // 4x4 with start pulse and changed inputs mid-draw
        v(1, 20, 30, 4, 4, 6, 1, 0, 1, 20, 30, 6);
        px(21, 30, 6, 1); px(22, 30, 6, 1); px(23, 30, 6, 1);
        v(1, 90, 10, 2, 2, 1, 1, 0, 1, 20, 31, 6);
        v(1, 90, 10, 2, 2, 1, 1, 0, 1, 21, 31, 6);
        px(22, 31, 6, 1); px(23, 31, 6, 1);
        px(20, 32, 6, 1); px(21, 32, 6, 1); px(22, 32, 6, 1); px(23, 32, 6, 1);
        px(20, 33, 6, 1); px(21, 33, 6, 1); px(22, 33, 6, 1); px(23, 33, 6, 1);
        dn(); id(); id();
        // Back-to-back with start held high
        v(1, 1, 2, 2, 1, 5, 1, 0, 1, 1, 2, 5);
        v(1, 1, 2, 2, 1, 5, 1, 0, 1, 2, 2, 5);
        v(1, 1, 2, 2, 1, 5, 1, 1, 0, 0, 0, 0);
        v(1, 1, 2, 2, 1, 5, 0, 0, 0, 0, 0, 0);
        v(1, 1, 2, 2, 1, 5, 1, 0, 1, 1, 2, 5);
        v(1, 1, 2, 2, 1, 5, 1, 0, 1, 2, 2, 5);
        dn(); id();

        resetn = 1'b0;
        drive(zero);
        repeat (2) @(negedge clk);
        check("reset_state", zero);
        resetn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted asynchronously during cycle 3 of a 5x1 draw
        drive(mk(1, 30, 40, 5, 1, 3, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        check("rst_draw_c1", mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 30, 40, 3));
        drive(zero);
        @(posedge clk);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1 check("rst_async_clear", zero);
        repeat (2) begin
            @(negedge clk);
            check("rst_held", zero);
        end
        resetn = 1'b1;
        @(negedge clk);
        check("rst_no_done", zero);
        drive(mk(1, 0, 0, 1, 1, 6, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        check("post_rst_pixel", mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 6));
        drive(zero);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_done", mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        check("post_rst_idle", zero);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
